// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for both ends of the TDM link.
//   - tdm_rx_state_t : receiver frame-tracking states
//   - PARITY_WORDS   : number of parity words that follow the last channel word
//   - frame_beats()  : total valid beats in one complete frame
// ---------------------------------------------------------------------------
package tdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } tdm_rx_state_t;

    // A frame is the channel words followed by exactly one parity word.
    localparam int unsigned PARITY_WORDS = 1;

    function automatic int unsigned frame_beats(input int unsigned nCh);
        return nCh + PARITY_WORDS;
    endfunction

endpackage : tdm_pkg

// File: rtl/xor_word_acc.sv
// ---------------------------------------------------------------------------
// xor_word_acc
// Running XOR of W-bit words, used both to generate and to check link parity.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the accumulator
//   clear_i : synchronous clear (highest priority)
//   load_i  : start a new accumulation with d_i
//   en_i    : fold d_i into the running value
//   d_i     : input word
//   acc_o   : current accumulated XOR
// ---------------------------------------------------------------------------
module xor_word_acc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    // Clear beats load, load beats accumulate; otherwise the value holds.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = d_i;
        end else if (en_i) begin
            acc_d = acc_q ^ d_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule : xor_word_acc

// File: rtl/tdm_demux_receiver.sv
// ---------------------------------------------------------------------------
// tdm_demux_receiver
// Receive end of the TDM link. Collects N_CH channel words of a frame into a
// parallel word, checks the trailing parity word, and reports framing errors
// when a new start-of-frame cuts a frame short.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   in_valid       : beat qualifier, invalid beats are ignored
//   in_sof         : start of frame (marks ch0), only meaningful with in_valid
//   in_data        : channel word or parity word
//   out_valid      : one-cycle pulse, frame complete
//   out_data       : ch0 in [W-1:0], chK in [K*W +: W]; held between pulses
//   out_parity_err : with out_valid, received parity != XOR of channels
//   out_frame_err  : one-cycle pulse, frame aborted by an early in_sof
// ---------------------------------------------------------------------------
module tdm_demux_receiver
    import tdm_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [W-1:0]      in_data,
    output logic              out_valid,
    output logic [N_CH*W-1:0] out_data,
    output logic              out_parity_err,
    output logic              out_frame_err
);

    localparam int CNT_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(N_CH - 1);

    tdm_rx_state_t     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [W-1:0]      ch_q [N_CH];
    logic [W-1:0]      acc;
    logic [N_CH*W-1:0] out_data_d;
    logic              out_valid_q;
    logic [N_CH*W-1:0] out_data_q;
    logic              out_parity_err_q;
    logic              out_frame_err_q;

    logic sofBeat;
    logic dataBeat;

    assign sofBeat  = in_valid && in_sof;
    assign dataBeat = in_valid && !in_sof && (state_q == DATA);

    // Parity accumulator: every sof restarts it, channel words fold in.
    xor_word_acc #(
        .W(W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (1'b0),
        .load_i  (sofBeat),
        .en_i    (dataBeat),
        .d_i     (in_data),
        .acc_o   (acc)
    );

    // Channel storage: ch0 is written by the sof beat, the rest by cnt decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                ch_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (k == 0) begin
                    if (sofBeat) begin
                        ch_q[k] <= in_data;
                    end
                end else if (dataBeat && (cnt_q == CNT_W'(k))) begin
                    ch_q[k] <= in_data;
                end
            end
        end
    end

    // Flatten the channel registers into the output word layout.
    always_comb begin
        out_data_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            out_data_d[k*W +: W] = ch_q[k];
        end
    end

    // Frame tracking FSM with registered outputs. An sof in any state restarts
    // the frame, and flags a framing error if a frame was already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_parity_err_q <= 1'b0;
            out_frame_err_q  <= 1'b0;
        end else begin
            out_valid_q      <= 1'b0;
            out_parity_err_q <= 1'b0;
            out_frame_err_q  <= 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    out_frame_err_q <= (state_q != IDLE);
                    state_q         <= DATA;
                    cnt_q           <= CNT_W'(1);
                end else begin
                    case (state_q)
                        DATA: begin
                            if (cnt_q == LAST_CH) begin
                                state_q <= PAR;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        PAR: begin
                            state_q          <= IDLE;
                            out_valid_q      <= 1'b1;
                            out_data_q       <= out_data_d;
                            out_parity_err_q <= (acc != in_data);
                        end
                        default: begin
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_parity_err = out_parity_err_q;
    assign out_frame_err  = out_frame_err_q;

endmodule : tdm_demux_receiver

// File: tb/tb_tdm_demux_receiver.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_receiver
// Directed scenarios plus randomized frames, checked cycle by cycle against a
// frame-level reference model built from a queue of received words.
// ---------------------------------------------------------------------------
module tb_tdm_demux_receiver;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_sof;
    logic [W-1:0]      in_data;
    logic              out_valid;
    logic [N_CH*W-1:0] out_data;
    logic              out_parity_err;
    logic              out_frame_err;

    int checkCount = 0;
    int passCount  = 0;
    int cycleNum   = 0;
    string phase   = "reset";

    // Reference model state: the words seen since the last sof.
    bit                inFrame;
    logic [W-1:0]      words[$];
    logic [N_CH*W-1:0] expData;
    bit                expValid;
    bit                expPerr;
    bit                expFerr;
    int                validCycles[$];

    always #5 clk = ~clk;

    tdm_demux_receiver #(
        .N_CH(N_CH),
        .W   (W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_sof         (in_sof),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_parity_err (out_parity_err),
        .out_frame_err  (out_frame_err)
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     phase, tag, actual, expected, cycleNum);
        end
    endtask

    // Frame-level model: decides what the outputs must show after this beat.
    task automatic modelBeat(input bit v, input bit s, input logic [W-1:0] d);
        logic [W-1:0] x;
        expValid = 1'b0;
        expPerr  = 1'b0;
        expFerr  = 1'b0;
        if (!v) return;
        if (s) begin
            expFerr = inFrame;
            words.delete();
            words.push_back(d);
            inFrame = 1'b1;
        end else if (inFrame) begin
            words.push_back(d);
            if (words.size() == N_CH + 1) begin
                x = '0;
                for (int i = 0; i < N_CH; i++) begin
                    x ^= words[i];
                    expData[i*W +: W] = words[i];
                end
                expValid = 1'b1;
                expPerr  = (x != words[N_CH]);
                inFrame  = 1'b0;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("out_valid",      64'(out_valid),      64'(expValid));
        checkOutput("out_frame_err",  64'(out_frame_err),  64'(expFerr));
        checkOutput("out_parity_err", 64'(out_parity_err), 64'(expPerr));
        checkOutput("out_data",       64'(out_data),       64'(expData));
    endtask

    // One clock of stimulus, then sample outputs 1 time unit after the edge.
    task automatic applyStimulus(input bit v, input bit s, input logic [W-1:0] d);
        modelBeat(v, s, d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        cycleNum++;
        if (out_valid === 1'b1) validCycles.push_back(cycleNum);
        checkAll();
    endtask

    task automatic sendFrame(input logic [N_CH*W-1:0] chans, input logic [W-1:0] par,
                             input int gap);
        for (int k = 0; k < N_CH; k++) begin
            applyStimulus(1'b1, k == 0, chans[k*W +: W]);
            repeat (gap) applyStimulus(1'b0, 1'b0, W'($urandom));
        end
        applyStimulus(1'b1, 1'b0, par);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic doReset();
        rst_n = 1'b0;
        inFrame = 1'b0;
        words.delete();
        expData  = '0;
        expValid = 1'b0;
        expPerr  = 1'b0;
        expFerr  = 1'b0;
        #2;
        checkAll();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N_CH*W-1:0] chans;
        logic [W-1:0]      par;
        int                len;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        #2;
        doReset();
        applyStimulus(1'b0, 1'b0, '0);

        phase = "t1";
        sendFrame(32'h44332211, 8'h44, 0);
        applyStimulus(1'b0, 1'b0, '0);

        phase = "t2";
        sendFrame(32'h44332211, 8'h45, 0);
        applyStimulus(1'b0, 1'b0, '0);

        phase = "t3";
        sendFrame(32'h44332211, 8'h44, 3);
        applyStimulus(1'b0, 1'b0, '0);

        phase = "t4";
        applyStimulus(1'b1, 1'b1, 8'hAA);
        applyStimulus(1'b1, 1'b0, 8'hBB);
        sendFrame(32'h04030201, 8'h04, 0);
        applyStimulus(1'b0, 1'b0, '0);

        phase = "t5";
        applyStimulus(1'b1, 1'b1, 8'h12);
        applyStimulus(1'b1, 1'b0, 8'h34);
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h55);
        applyStimulus(1'b1, 1'b0, 8'h66);
        applyStimulus(1'b1, 1'b0, 8'h77);
        applyStimulus(1'b1, 1'b0, 8'h88);
        applyStimulus(1'b1, 1'b0, 8'h99);
        applyStimulus(1'b0, 1'b0, '0);

        phase = "t6";
        validCycles.delete();
        sendFrame(32'hDDCCBBAA, 8'h00, 0);
        sendFrame(32'h87654321, 8'h11, 0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("pulse_count", 64'(validCycles.size()), 64'd2);
        if (validCycles.size() == 2) begin
            checkOutput("pulse_spacing", 64'(validCycles[1] - validCycles[0]), 64'd5);
        end

        phase = "rand";
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b1, 1'b0, W'($urandom));
            end
            if (f == 30) begin
                applyStimulus(1'b1, 1'b1, W'($urandom));
                doReset();
            end
            chans = '0;
            for (int k = 0; k < N_CH; k++) chans[k*W +: W] = W'($urandom);
            par = '0;
            for (int k = 0; k < N_CH; k++) par ^= chans[k*W +: W];
            if ($urandom_range(0, 2) == 0) par ^= W'($urandom_range(1, 255));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N_CH) : N_CH + 1;
            for (int b = 0; b < len; b++) begin
                if (b < N_CH) applyStimulus(1'b1, b == 0, chans[b*W +: W]);
                else          applyStimulus(1'b1, 1'b0, par);
                repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, W'($urandom));
            end
        end
        applyStimulus(1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_tdm_demux_receiver
